i2s_serializer: RTL and testbench

//  Stereo I2S transmitter stage downstream of the audio sample generator.

---
 rtl/i2s_serializer_if.sv | 31 +++
 rtl/i2s_serializer.sv | 73 +++++++
 tb/tb_i2s_serializer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/i2s_serializer_if.sv
// rtl/i2s_serializer_if.sv - sample source / DAC side signal bundle of the I2S serializer
interface i2s_serializer_if #(
   parameter int DATA_W = 24
);
   logic [DATA_W-1:0] l_data;
   logic [DATA_W-1:0] r_data;
   logic              load;
   logic              sclk;
   logic              lrclk;
   logic              sdout;

   // serializer side: takes samples, drives the strobe and the I2S lines
   modport master (
      input  l_data,
      input  r_data,
      output load,
      output sclk,
      output lrclk,
      output sdout
   );

   // source / DAC side
   modport slave (
      output l_data,
      output r_data,
      input  load,
      input  sclk,
      input  lrclk,
      input  sdout
   );
endinterface

// File: rtl/i2s_serializer.sv
// rtl/i2s_serializer.sv - Philips I2S transmitter, 32-bit slots, clocks derived from MCLK
module i2s_serializer #(
   parameter int SCLK_HALF = 4,
   parameter int DATA_W    = 24
) (
   input  logic              clk,
   input  logic              reset,
   i2s_serializer_if.master  bus
);
   localparam int DW = $clog2(2 * SCLK_HALF);
   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [DW-1:0] D_LAST  = DW'(2 * SCLK_HALF - 1);
   localparam logic [DW-1:0] SCLK_HI = DW'(SCLK_HALF);
   localparam logic [5:0]    LAST_L  = 6'(DATA_W);
   localparam logic [5:0]    LAST_R  = 6'(32 + DATA_W);

   logic [DW-1:0]     d;
   logic [5:0]        b;
   logic [DATA_W-1:0] l_hold;
   logic [DATA_W-1:0] r_hold;

   logic [DW-1:0]     nd;
   logic [5:0]        nb;
   logic              wrap;
   logic              sd_n;

   // Next counter state; every output register is loaded from a function of
   // the next (d, b) so the registered outputs line up with the counters.
   always_comb begin
      nd   = '0;
      nb   = b;
      wrap = 1'b0;
      sd_n = 1'b0;
      if (d == D_LAST) begin
         nb   = b + 6'd1;
         wrap = (b == 6'd63);
      end else begin
         nd = d + DW'(1);
      end
      if (nb >= 6'd1 && nb <= LAST_L) begin
         sd_n = l_hold[IW'(LAST_L - nb)];
      end else if (nb >= 6'd33 && nb <= LAST_R) begin
         sd_n = r_hold[IW'(LAST_R - nb)];
      end
   end

   // Counters, sample capture at the frame boundary, and registered I2S outputs.
   // Pad bits and bit 0 of each slot are driven low; samples are sent unmodified.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d         <= '0;
         b         <= '0;
         l_hold    <= '0;
         r_hold    <= '0;
         bus.sclk  <= 1'b0;
         bus.lrclk <= 1'b0;
         bus.sdout <= 1'b0;
         bus.load  <= 1'b0;
      end else begin
         d         <= nd;
         b         <= nb;
         bus.sclk  <= (nd >= SCLK_HI);
         bus.lrclk <= nb[5];
         bus.sdout <= sd_n;
         bus.load  <= (nd == '0) && (nb == 6'd63);
         if (wrap) begin
            l_hold <= bus.l_data;
            r_hold <= bus.r_data;
         end
      end
   end
endmodule

// File: tb/tb_i2s_serializer.sv
// tb/tb_i2s_serializer.sv - self-checking bench for i2s_serializer against a cycle-count reference model
`timescale 1ns/1ps
module tb_i2s_serializer;
   logic clk;
   logic reset;

   i2s_serializer_if #(.DATA_W(24)) ifc ();

   i2s_serializer #(.SCLK_HALF(4), .DATA_W(24)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          errors;
   int          checks;
   int          n;
   int          loads;
   logic [23:0] fl;
   logic [23:0] fr;
   logic [63:0] word;
   logic        prev_sclk;
   logic [23:0] cnt;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_sclk"},  ifc.sclk,  1'b0);
      chk({tag, "_lrclk"}, ifc.lrclk, 1'b0);
      chk({tag, "_sdout"}, ifc.sdout, 1'b0);
      chk({tag, "_load"},  ifc.load,  1'b0);
   endtask

   // Reference model: n counts clk edges since reset release; frame k starts at
   // n = 512k and carries the pair present on the inputs just before that edge.
   task automatic step();
      logic [23:0] pl;
      logic [23:0] pr;
      int          dd;
      int          bb;
      logic        e_sd;
      pl = ifc.l_data;
      pr = ifc.r_data;
      @(posedge clk);
      n++;
      if (n % 512 == 0) begin
         fl = pl;
         fr = pr;
      end
      #1;
      dd   = n % 8;
      bb   = (n / 8) % 64;
      e_sd = 1'b0;
      if (bb >= 1 && bb <= 24) e_sd = fl[24 - bb];
      else if (bb >= 33 && bb <= 56) e_sd = fr[56 - bb];
      chk("sclk",  ifc.sclk,  dd >= 4);
      chk("lrclk", ifc.lrclk, bb >= 32);
      chk("load",  ifc.load,  (n % 512) == 504);
      chk("sdout", ifc.sdout, e_sd);
      if (ifc.load) loads++;
      if (!prev_sclk && ifc.sclk) word = {word[62:0], ifc.sdout};
      prev_sclk = ifc.sclk;
      if (n % 512 == 511) chkw("frame_word", word, {1'b0, fl, 8'h00, fr, 7'h00});
   endtask

   task automatic release_model();
      n         = 0;
      fl        = '0;
      fr        = '0;
      word      = '0;
      prev_sclk = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      loads  = 0;
      cnt    = '0;
      release_model();
      reset      = 1'b0;
      ifc.l_data = '0;
      ifc.r_data = '0;

      repeat (3) @(posedge clk);
      #1;
      chk_zero("por");

      // free run with inputs changing every clk; only boundary values may appear
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 2048; i++) begin
         step();
         ifc.l_data = 24'($urandom);
         ifc.r_data = 24'($urandom);
      end
      chki("load_pulses_4_frames", loads, 4);

      // asynchronous reset in the middle of a frame
      repeat (100) step();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_zero("rst_now");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk_zero("rst_hold");
      end
      @(negedge clk);
      release_model();
      reset = 1'b1;

      // constant pattern; first frame after release is zeros, second carries it
      ifc.l_data = 24'hA5A5A5;
      ifc.r_data = 24'h5A5A5A;
      repeat (1024) step();

      // full-scale extremes: no sign extension into pad bits
      ifc.l_data = 24'h800000;
      ifc.r_data = 24'h7FFFFF;
      repeat (1024) step();

      // source model updating one clk after each load strobe
      cnt        = 24'd1;
      ifc.l_data = cnt;
      ifc.r_data = ~cnt;
      repeat (1536) begin
         step();
         if (ifc.load) begin
            cnt        = cnt + 24'd1;
            ifc.l_data = cnt;
            ifc.r_data = ~cnt;
         end
      end

      // mid-frame change at b=10 must not disturb the current frame
      ifc.l_data = 24'h123456;
      ifc.r_data = 24'h654321;
      repeat ((512 - (n % 512)) % 512) step();
      repeat (80) step();
      ifc.l_data = 24'hFEDCBA;
      repeat (1024 - 80) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
